hgcal_fc_param_serializer: RTL and testbench

Parametrised N:1 fast-control serializer for NCH lanes, running entirely in the fast clock domain. Frame alignment comes from a one-cycle sync pulse that the upstream slow-clock edge detector generates in the fast domain. Adds selectable MSB/LSB-first order, idle-word insertion when no data is valid, and frame-lock/misalignment monitoring. It sits between the fast-command encoder and the output pins/ODDR stage, replacing fixed 8:1 serialization.

---
 rtl/hgcal_fc_param_serializer_if.sv | 25 ++
 rtl/hgcal_fc_param_serializer.sv | 96 +++++++++
 tb/tb_hgcal_fc_param_serializer.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/hgcal_fc_param_serializer_if.sv
// rtl/hgcal_fc_param_serializer_if.sv - parallel-word / serial-lane bundle for the fast-control serializer
interface hgcal_fc_param_serializer_if #(
   parameter int RATIO = 8,
   parameter int NCH   = 1
);
   logic                   sync_in;
   logic [NCH*RATIO-1:0]   data_in;
   logic                   data_valid;
   logic                   msb_first;
   logic [NCH-1:0]         serial_out;
   logic                   frame_start;
   logic                   word_ack;
   logic                   locked;
   logic [7:0]             misalign_count;

   modport master (
      output sync_in, data_in, data_valid, msb_first,
      input  serial_out, frame_start, word_ack, locked, misalign_count
   );

   modport slave (
      input  sync_in, data_in, data_valid, msb_first,
      output serial_out, frame_start, word_ack, locked, misalign_count
   );
endinterface

// File: rtl/hgcal_fc_param_serializer.sv
// rtl/hgcal_fc_param_serializer.sv - N:1 multi-lane fast-control serializer with frame-lock monitor
module hgcal_fc_param_serializer #(
   parameter int               RATIO      = 8,
   parameter int               NCH        = 1,
   parameter logic [RATIO-1:0] IDLE_WORD  = 'hAC,
   parameter int               LOCK_COUNT = 4
) (
   input  logic                          clk320,
   input  logic                          reset_n,
   hgcal_fc_param_serializer_if.slave    bus
);
   localparam int             PW      = $clog2(RATIO);
   localparam logic [PW-1:0]  PH_LAST = PW'(RATIO - 1);
   localparam logic [3:0]     LOCK_N  = 4'(LOCK_COUNT);

   logic [PW-1:0]             ph_q, ph_d;
   logic [NCH-1:0][RATIO-1:0] sreg_q, sreg_d;
   logic                      order_q, order_d;
   logic [NCH-1:0]            serial_q, serial_d;
   logic                      load_q, load_d;
   logic                      frame_q, frame_d;
   logic                      ack_q, ack_d;
   logic                      locked_q, locked_d;
   logic [3:0]                good_q, good_d;
   logic [7:0]                mis_q, mis_d;
   logic                      at_last;
   logic                      load;

   always_comb begin
      at_last  = (ph_q == PH_LAST);
      load     = at_last || bus.sync_in;
      ph_d     = load ? '0 : ph_q + PW'(1);
      order_d  = load ? bus.msb_first : order_q;
      sreg_d   = sreg_q;
      serial_d = serial_q;
      for (int c = 0; c < NCH; c++) begin
         serial_d[c] = order_q ? sreg_q[c][RATIO-1] : sreg_q[c][0];
         if (load)
            sreg_d[c] = bus.data_valid ? bus.data_in[c*RATIO +: RATIO] : IDLE_WORD;
         else if (order_q)
            sreg_d[c] = {sreg_q[c][RATIO-2:0], 1'b0};
         else
            sreg_d[c] = {1'b0, sreg_q[c][RATIO-1:1]};
      end
      // load is carried one extra stage so frame_start coincides with the first serial bit
      load_d   = load;
      frame_d  = load_q;
      ack_d    = load && bus.data_valid;
      good_d   = good_q;
      locked_d = locked_q;
      mis_d    = mis_q;
      if (bus.sync_in) begin
         if (at_last) begin
            good_d = (good_q >= LOCK_N) ? LOCK_N : good_q + 4'd1;
            if (good_d == LOCK_N)
               locked_d = 1'b1;
         end else begin
            good_d   = '0;
            locked_d = 1'b0;
            mis_d    = (mis_q == 8'hFF) ? mis_q : mis_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk320 or negedge reset_n) begin
      if (!reset_n) begin
         ph_q     <= '0;
         sreg_q   <= '0;
         order_q  <= 1'b1;
         serial_q <= '0;
         load_q   <= 1'b0;
         frame_q  <= 1'b0;
         ack_q    <= 1'b0;
         locked_q <= 1'b0;
         good_q   <= '0;
         mis_q    <= '0;
      end else begin
         ph_q     <= ph_d;
         sreg_q   <= sreg_d;
         order_q  <= order_d;
         serial_q <= serial_d;
         load_q   <= load_d;
         frame_q  <= frame_d;
         ack_q    <= ack_d;
         locked_q <= locked_d;
         good_q   <= good_d;
         mis_q    <= mis_d;
      end
   end

   assign bus.serial_out     = serial_q;
   assign bus.frame_start    = frame_q;
   assign bus.word_ack       = ack_q;
   assign bus.locked         = locked_q;
   assign bus.misalign_count = mis_q;
endmodule

// File: tb/tb_hgcal_fc_param_serializer.sv
// tb/tb_hgcal_fc_param_serializer.sv - scoreboard bench for the fast-control serializer
module tb_hgcal_fc_param_serializer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hgcal_fc_param_serializer_if #(.RATIO(8),  .NCH(1)) if8();
   hgcal_fc_param_serializer_if #(.RATIO(10), .NCH(3)) if10();

   hgcal_fc_param_serializer #(.RATIO(8), .NCH(1), .IDLE_WORD(8'hAC), .LOCK_COUNT(4))
      u_dut8 (.clk320(clk), .reset_n(rst_n), .bus(if8));
   hgcal_fc_param_serializer #(.RATIO(10), .NCH(3), .IDLE_WORD(10'h2C3), .LOCK_COUNT(4))
      u_dut10 (.clk320(clk), .reset_n(rst_n), .bus(if10));

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // expected transmit sequences, first bit in the MSB position of each lane field
   logic [7:0]  exp8_q[$];
   logic [29:0] exp10_q[$];
   bit          busy8, busy10;
   int          idx8, idx10;
   logic [7:0]  cur8, got8;
   logic [29:0] cur10, got10;
   int          ack8_cnt = 0;
   int          ack10_cnt = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         busy8 = 1'b0;
      end else begin
         if (if8.word_ack) ack8_cnt++;
         if (if8.frame_start) begin
            if (busy8) check("sb8_frame_early", 32'(idx8), 32'd8);
            busy8 = 1'b0;
            if (exp8_q.size() > 0) begin
               cur8  = exp8_q.pop_front();
               busy8 = 1'b1;
               idx8  = 0;
            end
         end
         if (busy8) begin
            got8[7-idx8] = if8.serial_out[0];
            idx8++;
            if (idx8 == 8) begin
               check("sb8_word", 32'(got8), 32'(cur8));
               busy8 = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst_n) begin
         busy10 = 1'b0;
      end else begin
         if (if10.word_ack) ack10_cnt++;
         if (if10.frame_start) begin
            if (busy10) check("sb10_frame_early", 32'(idx10), 32'd10);
            busy10 = 1'b0;
            if (exp10_q.size() > 0) begin
               cur10  = exp10_q.pop_front();
               busy10 = 1'b1;
               idx10  = 0;
            end
         end
         if (busy10) begin
            for (int c = 0; c < 3; c++) got10[c*10 + 9 - idx10] = if10.serial_out[c];
            idx10++;
            if (idx10 == 10) begin
               check("sb10_word", 32'(got10), 32'(cur10));
               busy10 = 1'b0;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // sync/load edge followed by RATIO-1 quiet edges; inputs are scrambled after load
   task automatic frame8(input logic [7:0] w, input logic v, input logic m,
                         input logic [7:0] e, input bit push);
      if8.data_in = w; if8.data_valid = v; if8.msb_first = m; if8.sync_in = 1'b1;
      tick();
      if (push) exp8_q.push_back(e);
      if8.sync_in = 1'b0; if8.data_valid = 1'b0; if8.msb_first = ~m; if8.data_in = ~w;
      repeat (7) tick();
   endtask

   task automatic frame10(input logic [29:0] w, input logic v, input logic m, input logic [29:0] e);
      if10.data_in = w; if10.data_valid = v; if10.msb_first = m; if10.sync_in = 1'b1;
      tick();
      exp10_q.push_back(e);
      if10.sync_in = 1'b0; if10.data_valid = 1'b0; if10.msb_first = ~m; if10.data_in = ~w;
      repeat (9) tick();
   endtask

   task automatic drain8();
      for (int i = 0; i < 40; i++) begin
         if (exp8_q.size() == 0 && !busy8) break;
         tick();
      end
      check("sb8_drain", 32'(exp8_q.size()) + 32'(busy8), 32'd0);
   endtask

   task automatic drain10();
      for (int i = 0; i < 40; i++) begin
         if (exp10_q.size() == 0 && !busy10) break;
         tick();
      end
      check("sb10_drain", 32'(exp10_q.size()) + 32'(busy10), 32'd0);
   endtask

   logic [7:0]  t_w [8] = '{8'hA5, 8'hA5, 8'h01, 8'h01, 8'hC0, 8'h5A, 8'h5A, 8'h5A};
   logic        t_v [8] = '{1'b1,  1'b1,  1'b1,  1'b1,  1'b1,  1'b0,  1'b0,  1'b0};
   logic        t_m [8] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};
   logic [7:0]  t_e [8] = '{8'hA5, 8'hA5, 8'h80, 8'h01, 8'h03, 8'hAC, 8'hAC, 8'h35};
   int          ack_base;

   initial begin
      if8.sync_in = 1'b0;  if8.data_in = '0;  if8.data_valid = 1'b0;  if8.msb_first = 1'b1;
      if10.sync_in = 1'b0; if10.data_in = '0; if10.data_valid = 1'b0; if10.msb_first = 1'b1;
      repeat (3) tick();
      check("rst_serial",   32'(if8.serial_out), 32'd0);
      check("rst_frame",    32'(if8.frame_start), 32'd0);
      check("rst_ack",      32'(if8.word_ack), 32'd0);
      check("rst_locked",   32'(if8.locked), 32'd0);
      check("rst_misalign", 32'(if8.misalign_count), 32'd0);
      check("rst_serial10", 32'(if10.serial_out), 32'd0);
      rst_n = 1'b1;
      repeat (7) tick();

      // MSB/LSB order, several words, idle insertion
      ack_base = ack8_cnt;
      for (int i = 0; i < 8; i++) frame8(t_w[i], t_v[i], t_m[i], t_e[i], 1'b1);
      drain8();
      check("ack8_count", 32'(ack8_cnt - ack_base), 32'd5);
      check("locked_stream", 32'(if8.locked), 32'd1);
      check("misalign_stream", 32'(if8.misalign_count), 32'd0);

      // lock acquisition and misalignment handling
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (3) tick();
      frame8(8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
      check("mis_first_sync", 32'(if8.misalign_count), 32'd1);
      check("lock_after_mis", 32'(if8.locked), 32'd0);
      for (int i = 0; i < 4; i++) begin
         frame8(8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
         if (i == 2) check("lock_after_3", 32'(if8.locked), 32'd0);
      end
      check("lock_after_4", 32'(if8.locked), 32'd1);
      if8.sync_in = 1'b1; if8.data_valid = 1'b0;
      tick();
      if8.sync_in = 1'b0;
      repeat (4) tick();
      if8.data_in = 8'hF0; if8.data_valid = 1'b1; if8.msb_first = 1'b1; if8.sync_in = 1'b1;
      tick();
      exp8_q.push_back(8'hF0);
      if8.sync_in = 1'b0; if8.data_valid = 1'b0;
      check("lock_drop", 32'(if8.locked), 32'd0);
      check("mis_second", 32'(if8.misalign_count), 32'd2);
      tick();
      check("trunc_frame_start", 32'(if8.frame_start), 32'd1);
      check("trunc_first_bit", 32'(if8.serial_out), 32'd1);
      repeat (6) tick();
      for (int i = 0; i < 4; i++) frame8(8'h00, 1'b0, 1'b1, 8'h00, 1'b0);
      check("relock", 32'(if8.locked), 32'd1);
      check("mis_held", 32'(if8.misalign_count), 32'd2);

      // asynchronous reset mid-word
      if8.data_in = 8'hFF; if8.data_valid = 1'b1; if8.sync_in = 1'b1;
      tick();
      if8.sync_in = 1'b0; if8.data_valid = 1'b0;
      repeat (2) tick();
      check("pre_reset_bit", 32'(if8.serial_out), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check("async_serial", 32'(if8.serial_out), 32'd0);
      check("async_frame",  32'(if8.frame_start), 32'd0);
      check("async_locked", 32'(if8.locked), 32'd0);
      check("async_mis",    32'(if8.misalign_count), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      check("post_rst_serial", 32'(if8.serial_out), 32'd0);
      check("post_rst_frame",  32'(if8.frame_start), 32'd0);
      repeat (6) tick();
      frame8(8'h3C, 1'b1, 1'b1, 8'h3C, 1'b1);
      frame8(8'hC0, 1'b1, 1'b0, 8'h03, 1'b1);
      drain8();
      check("post_rst_mis", 32'(if8.misalign_count), 32'd0);
      check("post_rst_lock", 32'(if8.locked), 32'd0);

      // three lanes at ratio 10 sharing one frame
      if10.sync_in = 1'b1;
      tick();
      if10.sync_in = 1'b0;
      repeat (9) tick();
      ack_base = ack10_cnt;
      frame10({10'h2AA, 10'h000, 10'h3FF}, 1'b1, 1'b1, {10'h2AA, 10'h000, 10'h3FF});
      frame10({10'h2AA, 10'h000, 10'h3FF}, 1'b1, 1'b0, {10'h155, 10'h000, 10'h3FF});
      frame10({10'h111, 10'h222, 10'h333}, 1'b0, 1'b1, {10'h2C3, 10'h2C3, 10'h2C3});
      drain10();
      check("ack10_count", 32'(ack10_cnt - ack_base), 32'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
